// File: rtl/ff_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ff_pipe
// Brief   : DEPTH-stage valid/ready register pipeline with bubble collapse,
//           synchronous flush and async active-low reset. Optional occupancy
//           counter and port under FF_PIPE_OCCUPANCY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ff_pipe #(
    parameter int                WIDTH   = 8,
    parameter int                DEPTH   = 3,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef FF_PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            w_adv;
    logic [DEPTH-1:0]            w_vin;
    logic [DEPTH-1:0][WIDTH-1:0] w_din;

    // A stage is blocked only when it and every stage after it are full and
    // the sink stalls; this is the unrolled form of !v[i] | adv[i+1].
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            assign w_adv[i] = out_ready | ~(&r_valid[DEPTH-1:i]);
            if (i == 0) begin : g_head
                assign w_vin[i] = in_valid;
                assign w_din[i] = in_data;
            end else begin : g_body
                assign w_vin[i] = r_valid[i-1];
                assign w_din[i] = r_data[i-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            r_valid <= (w_adv & w_vin) | (~w_adv & r_valid);
        end
    end

    // Data follows the advance terms only; flush leaves payloads in place.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_adv[i]) begin
                    r_data[i] <= w_din[i];
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

`ifdef FF_PIPE_OCCUPANCY_EN
    localparam int                  c_occ_w = $clog2(DEPTH + 1);
    localparam logic [c_occ_w-1:0]  c_one   = c_occ_w'(1);

    logic               w_accept;
    logic               w_emit;
    logic [c_occ_w-1:0] r_occ;

    assign w_accept = in_valid & w_adv[0];
    assign w_emit   = r_valid[DEPTH-1] & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, w_emit})
                2'b10:   r_occ <= r_occ + c_one;
                2'b01:   r_occ <= r_occ - c_one;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occupancy = r_occ;

    a_occ_matches_valid: assert property (@(posedge clk) disable iff (!rstn)
        int'(r_occ) == $countones(r_valid));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ff_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_ff_pipe
// Brief   : Directed self-checking bench for ff_pipe (WIDTH 8, DEPTH 3,
//           RST_VAL 8'hA5).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ff_pipe;

    localparam int              WIDTH   = 8;
    localparam int              DEPTH   = 3;
    localparam logic [7:0]      RST_VAL = 8'hA5;

    logic             clk;
    logic             rstn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef FF_PIPE_OCCUPANCY_EN
    logic [1:0]       occupancy;
`endif

    int n_checks;
    int n_errors;

    ff_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FF_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occupancy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_occ(input string tag, input logic [31:0] exp);
`ifdef FF_PIPE_OCCUPANCY_EN
        chk(tag, {30'd0, occupancy}, exp);
`else
        if (exp > 32'd3) $display("note: %s out of range", tag);
`endif
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_out_data", {24'd0, out_data}, 32'hA5);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk_occ("rst_occ", 32'd0);
        rstn = 1'b1;
        tick();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- streaming 01..08 ----------------
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            #1;
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            if (k >= 3) begin
                chk("stream_valid", {31'd0, out_valid}, 32'd1);
                chk("stream_data", {24'd0, out_data}, 32'(k - 2));
            end else begin
                chk("stream_fill_valid", {31'd0, out_valid}, 32'd0);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("stream_tail7", {23'd0, out_valid, out_data}, 32'h107);
        tick();
        chk("stream_tail8", {23'd0, out_valid, out_data}, 32'h108);
        tick();
        chk("stream_empty", {31'd0, out_valid}, 32'd0);

        // ---------------- stall / full ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h10; #1; chk("stall_rdy10", {31'd0, in_ready}, 32'd1); tick();
        in_data   = 8'h11; #1; chk("stall_rdy11", {31'd0, in_ready}, 32'd1); tick();
        in_data   = 8'h12; #1; chk("stall_rdy12", {31'd0, in_ready}, 32'd1); tick();
        chk("stall_head", {23'd0, out_valid, out_data}, 32'h110);
        chk_occ("stall_occ_full", 32'd3);
        in_data   = 8'h13; #1;
        chk("stall_full_rdy", {31'd0, in_ready}, 32'd0);
        tick();
        chk("stall_hold_data", {23'd0, out_valid, out_data}, 32'h110);
        chk("stall_hold_rdy", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1; #1;
        chk("release_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("release_11", {23'd0, out_valid, out_data}, 32'h111);
        chk_occ("release_occ", 32'd3);
        tick();
        chk("release_12", {23'd0, out_valid, out_data}, 32'h112);
        tick();
        chk("release_13", {23'd0, out_valid, out_data}, 32'h113);
        tick();
        chk("release_empty", {31'd0, out_valid}, 32'd0);

        // ---------------- bubble collapse ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 8'h20; tick();
        in_valid  = 1'b0; tick();
        tick();
        in_valid  = 1'b1; in_data = 8'h21; tick();
        in_valid  = 1'b0; tick();
        chk("bubble_head", {23'd0, out_valid, out_data}, 32'h120);
        chk("bubble_rdy", {31'd0, in_ready}, 32'd1);
        chk_occ("bubble_occ", 32'd2);
        out_ready = 1'b1;
        tick();
        chk("bubble_next", {23'd0, out_valid, out_data}, 32'h121);
        tick();
        chk("bubble_empty", {31'd0, out_valid}, 32'd0);

        // ---------------- flush ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h40; tick();
        in_data   = 8'h41; tick();
        in_data   = 8'h42; tick();
        chk("flush_prefill", {23'd0, out_valid, out_data}, 32'h140);
        out_ready = 1'b1;
        flush     = 1'b1;
        in_data   = 8'h30; #1;
        chk("flush_cycle_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_rdy", {31'd0, in_ready}, 32'd1);
        chk_occ("flush_occ", 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("flush_no_30", {31'd0, out_valid}, 32'd0);
        end

        // ---------------- simultaneous accept/emit ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h50; tick();
        in_data   = 8'h51; tick();
        in_data   = 8'h52; tick();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 8'(8'h53 + k);
            #1;
            chk("simul_rdy", {31'd0, in_ready}, 32'd1);
            tick();
            chk("simul_out", {23'd0, out_valid, out_data}, 32'h100 | 32'(8'h51 + k));
            chk_occ("simul_occ", 32'd3);
        end
        in_valid = 1'b0;
        tick();
        chk("simul_drain5b", {23'd0, out_valid, out_data}, 32'h15B);
        tick();
        chk("simul_drain5c", {23'd0, out_valid, out_data}, 32'h15C);
        tick();
        chk("simul_empty", {31'd0, out_valid}, 32'd0);

        // ---------------- reset mid-stream ----------------
        in_valid = 1'b1;
        in_data  = 8'h60; tick();
        in_data  = 8'h61; tick();
        in_data  = 8'h62; tick();
        chk("mid_pre", {23'd0, out_valid, out_data}, 32'h160);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, out_data}, 32'hA5);
        chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("mid_after_valid", {31'd0, out_valid}, 32'd0);
        chk_occ("mid_after_occ", 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ff_pipe.md
# ff_pipe

Parametrised multi-stage register pipeline with a valid/ready handshake, the successor to the single-flop test designs in the `read-systemverilog` regression set. It carries a `WIDTH`-bit payload through `DEPTH` flop stages, supports backpressure with bubble collapsing, and applies a synchronous flush. All stages reset asynchronously to a parametrised value. It is the standard delay/retiming primitive for multi-cycle datapaths in the suite.

## Interface
- `WIDTH`, 8, payload width in bits; must be ≥1.
- `DEPTH`, 3, number of register stages; must be ≥1.
- `RST_VAL`, `'0`, `WIDTH`-bit value loaded into every data stage on reset.
- `clk`  input  1  rising-edge clock.
- `rstn`  input  1  reset; one clock; reset is asynchronous and active-low.
- `flush`  input  1  synchronous clear of all stage valids.
- `in_valid`  input  1  upstream data valid.
- `in_ready`  output  1  pipeline can accept `in_data` this cycle.
- `in_data`  input  `WIDTH`  upstream payload.
- `out_valid`  output  1  last stage holds valid data.
- `out_ready`  input  1  downstream accepts `out_data` this cycle.
- `out_data`  output  `WIDTH`  payload of the last stage.
- `occupancy`  output  `$clog2(DEPTH+1)`  count of valid stages; present only with `FF_PIPE_OCCUPANCY_EN`.

## Operation
- Stages are numbered 0 (input) to `DEPTH-1` (output). Each stage has a valid bit `v[i]` and a data register `d[i]`.
- Stage advance term:
  - `adv[DEPTH-1] = !v[DEPTH-1] | out_ready`.
  - `adv[i] = !v[i] | adv[i+1]`.
  - `in_ready = adv[0]`.
- On a clock edge where `adv[i]` is 1:
  - Stage 0 loads `v[0] <= in_valid` and `d[0] <= in_data`.
  - Stage i>0 loads `v[i] <= v[i-1]` and `d[i] <= d[i-1]`.
- Where `adv[i]` is 0, the stage holds its valid bit and data.
- Bubble collapse: an empty stage always accepts, so gaps close under a downstream stall.
- `d[i]` updates only when `adv[i]` is 1. Data is not gated by valid; an invalid stage may hold stale data.
- `out_valid = v[DEPTH-1]` and `out_data = d[DEPTH-1]`, both driven straight from flops.
- `flush`:
  - On the edge, all `v[i]` clear to 0. This overrides the advance terms and discards any input offered in that cycle.
  - Data registers are not cleared.
  - `in_ready` is still computed from the current state during the flush cycle. Upstream must treat a beat accepted in a flush cycle as dropped.
- Reset (`rstn` low), asynchronous and immediate:
  - All `v[i]` = 0 and all `d[i]` = `RST_VAL`.
  - Outputs: `out_valid` = 0, `out_data` = `RST_VAL`, `in_ready` = 1, `occupancy` = 0.
- Reset asserted mid-transfer discards all in-flight beats. After `rstn` deasserts, the first edge behaves as from empty.

## Timing
- Latency: a beat accepted at edge N appears on `out_valid`/`out_data` after edge N+`DEPTH-1`, i.e. visible in the cycle after `DEPTH` edges from the input. With no stall, throughput is 1 beat/cycle.
- `in_ready` depends combinationally on `out_ready` through a `DEPTH`-long chain. This is accepted; there is no skid buffer.
- Full: all `v`=1 and `out_ready`=0 gives `in_ready`=0. If `out_ready`=1 in the same cycle, `in_ready`=1; simultaneous accept and emit keeps occupancy constant.
- Empty: `out_valid`=0. An input beat reaches the output after `DEPTH` edges regardless of `out_ready`.
- `occupancy` is registered and updated each edge as follows:
  - Increments when accept is 1 and emit is 0, where accept = `in_valid & in_ready` and emit = `out_valid & out_ready`.
  - Decrements when emit is 1 and accept is 0.
  - Holds when both or neither occur.
  - Goes to 0 on flush.
  - Never exceeds `DEPTH`.

## Configuration
- `FF_PIPE_OCCUPANCY_EN` defined:
  - The `occupancy` port and its counter are compiled in.
  - An assertion is also compiled in: `occupancy` equals the popcount of `v`.
- Not defined: the port, counter and assertion are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rstn`=0 with `RST_VAL`=8'hA5 → `out_data`=8'hA5, `out_valid`=0, `in_ready`=1; assert `rstn` low mid-stream → `out_valid` drops immediately.
- Streaming, `DEPTH`=3: drive 8'h01..8'h08 on consecutive cycles with `out_ready`=1 → 8'h01 first visible 3 edges after acceptance, then one beat per cycle in order with no gaps.
- Stall/full: hold `out_ready`=0 while sending 8'h10,8'h11,8'h12,8'h13 → the first three are accepted and `in_ready`=0 after the third; 8'h13 is held upstream. Release → output 8'h10..8'h13 in order with none lost or duplicated.
- Bubble collapse: send 8'h20, idle 2 cycles, send 8'h21, with `out_ready`=0 → both beats end in adjacent stages, `occupancy`=2; release → back-to-back output.
- Flush: fill 3 beats, pulse `flush` with `in_valid`=1 and data 8'h30 → next cycle `out_valid`=0, `occupancy`=0, and 8'h30 never emerges.
- Simultaneous: full pipe with `in_valid`=1 and `out_ready`=1 for 10 cycles → `occupancy` stays at 3 and the output order matches the input.
